// File: rtl/disp_pkg.sv
// Shared constants, state encoding and width helper for the display-share arbiter.
package disp_pkg;

  localparam int DISP_W  = 32;
  localparam int DIGIT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OWN    = 2'd1,
    SWITCH = 2'd2
  } arb_state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic          any_o,
  output logic [IW-1:0] winner_o
);

  logic [2*N-1:0] masked;

  // Lower copy is masked below ptr; the upper copy supplies the wrapped candidates.
  always_comb begin
    masked = {req_i, req_i};
    for (int i = 0; i < N; i++) begin
      if (IW'(i) < ptr_i) masked[i] = 1'b0;
    end
    any_o    = |req_i;
    winner_o = '0;
    for (int i = 2*N-1; i >= 0; i--) begin
      if (masked[i]) winner_o = (i >= N) ? IW'(i - N) : IW'(i);
    end
  end

endmodule

// File: rtl/disp_share_arbiter.sv
// Round-robin owner of the 8-digit display with a minimum hold time and a
// one-cycle blank gap between owners; forwards the owner's word on disp_o.
module disp_share_arbiter
  import disp_pkg::*;
#(
  parameter int          N_REQ        = 4,
  parameter int          HOLD_CLOCKS  = 50_000_000,
  parameter logic [31:0] IDLE_PATTERN = 32'h0000_0000
) (
  input  logic                      clk,
  input  logic                      rst_i,
  input  logic [N_REQ-1:0]          req_i,
  input  logic [32*N_REQ-1:0]       data_i,
  output logic [N_REQ-1:0]          gnt_o,
  output logic [idx_w(N_REQ)-1:0]   owner_o,
  output logic                      valid_o,
  output logic [31:0]               disp_o,
  output logic [1:0]                state_o
);

  // Handshake: req_i is a level request held while a requester wants the
  // display; gnt_o is high exactly while it owns it. Lowering req_i releases,
  // and every change of owner passes through one SWITCH cycle with gnt_o=0.

  localparam int IW = idx_w(N_REQ);
  localparam int CW = $clog2(HOLD_CLOCKS + 1);
  localparam logic [CW-1:0]    HOLD_LAST = CW'(HOLD_CLOCKS - 1);
  localparam logic [N_REQ-1:0] ONE       = N_REQ'(1);

  arb_state_t        state, state_nx;
  logic [IW-1:0]     owner, ptr, winner;
  logic [CW-1:0]     hold_cnt;
  logic              any_req, grant, others;
  logic [N_REQ-1:0]  owner_oh;
  logic [31:0]       owner_word;

  rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
    .req_i    (req_i),
    .ptr_i    (ptr),
    .any_o    (any_req),
    .winner_o (winner)
  );

  assign owner_oh = ONE << owner;
  assign others   = |(req_i & ~owner_oh);

  always_comb begin
    owner_word = IDLE_PATTERN;
    for (int k = 0; k < N_REQ; k++) begin
      if (owner == IW'(k)) owner_word = data_i[k*DISP_W +: DISP_W];
    end
  end

  always_comb begin
    state_nx = state;
    grant    = 1'b0;
    case (state)
      IDLE, SWITCH: begin
        if (any_req) begin
          state_nx = OWN;
          grant    = 1'b1;
        end else begin
          state_nx = IDLE;
        end
      end
      OWN: begin
        if (!req_i[owner] || (hold_cnt == HOLD_LAST && others)) state_nx = SWITCH;
      end
      default: state_nx = IDLE;
    endcase
  end

  // The pointer moves on entry to SWITCH so that cycle's search already uses it.
  always_ff @(posedge clk) begin
    if (!rst_i) begin
      state    <= IDLE;
      owner    <= '0;
      ptr      <= '0;
      hold_cnt <= '0;
      disp_o   <= IDLE_PATTERN;
    end else begin
      state <= state_nx;
      if (grant) begin
        owner    <= winner;
        hold_cnt <= '0;
      end else if (state == OWN && hold_cnt != HOLD_LAST) begin
        hold_cnt <= hold_cnt + 1'b1;
      end
      if (state == OWN && state_nx == SWITCH)
        ptr <= (owner == IW'(N_REQ - 1)) ? '0 : owner + 1'b1;
      disp_o <= (state == OWN && state_nx == OWN) ? owner_word : IDLE_PATTERN;
    end
  end

  assign valid_o = (state == OWN);
  assign gnt_o   = valid_o ? owner_oh : '0;
  assign owner_o = owner;
  assign state_o = state;

endmodule

// File: tb/tb_disp_share_arbiter.sv
// Directed bench for disp_share_arbiter with N_REQ=4, HOLD_CLOCKS=4.
module tb_disp_share_arbiter;
  import disp_pkg::*;

  logic         clk = 1'b0;
  logic         rst_i;
  logic [3:0]   req_i;
  logic [127:0] data_i;
  logic [3:0]   gnt_o;
  logic [1:0]   owner_o;
  logic         valid_o;
  logic [31:0]  disp_o;
  logic [1:0]   state_o;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_word [4];

  disp_share_arbiter #(
    .N_REQ        (4),
    .HOLD_CLOCKS  (4),
    .IDLE_PATTERN (32'h0000_0000)
  ) dut (
    .clk     (clk),
    .rst_i   (rst_i),
    .req_i   (req_i),
    .data_i  (data_i),
    .gnt_o   (gnt_o),
    .owner_o (owner_o),
    .valid_o (valid_o),
    .disp_o  (disp_o),
    .state_o (state_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  // driver
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // scoreboard comparison
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // grant invariants sampled on the falling edge
  always @(negedge clk) begin
    if (rst_i === 1'b1) begin
      checks++;
      assert ($onehot0(gnt_o) && ((gnt_o != 4'b0) == valid_o)) else begin
        failures++;
        $error("FAIL invariant observed gnt=%0h valid=%0b expected onehot0 and gnt!=0 iff valid",
               gnt_o, valid_o);
      end
    end
  end

  initial begin
    exp_word[0] = 32'h1111_1111;
    exp_word[1] = 32'h2222_2222;
    exp_word[2] = 32'hCAFE_F00D;
    exp_word[3] = 32'h3333_3333;
    data_i = {32'h3333_3333, 32'hDEAD_BEEF, 32'h2222_2222, 32'h1111_1111};

    // reset with all requests high
    rst_i = 1'b0;
    req_i = 4'b1111;
    step();
    step();
    chk("rst_gnt",   32'(gnt_o),   32'h0);
    chk("rst_valid", 32'(valid_o), 32'h0);
    chk("rst_disp",  disp_o,       32'h0);
    chk("rst_owner", 32'(owner_o), 32'h0);
    chk("rst_state", 32'(state_o), 32'(IDLE));

    rst_i = 1'b1;
    req_i = 4'b0000;
    step();
    step();
    chk("idle_gnt",   32'(gnt_o),   32'h0);
    chk("idle_valid", 32'(valid_o), 32'h0);
    chk("idle_disp",  disp_o,       32'h0);
    chk("idle_state", 32'(state_o), 32'(IDLE));

    // single grant, one-cycle latency, disp lags by one cycle
    req_i = 4'b0100;
    step();
    chk("sg_gnt",   32'(gnt_o),   32'h4);
    chk("sg_owner", 32'(owner_o), 32'h2);
    chk("sg_valid", 32'(valid_o), 32'h1);
    chk("sg_disp0", disp_o,       32'h0);
    chk("sg_state", 32'(state_o), 32'(OWN));
    step();
    chk("sg_disp1", disp_o, 32'hDEAD_BEEF);
    for (int i = 0; i < 20; i++) begin
      step();
      chk("sg_hold_gnt",  32'(gnt_o), 32'h4);
      chk("sg_hold_disp", disp_o,     32'hDEAD_BEEF);
    end
    data_i[95:64] = 32'hCAFE_F00D;
    step();
    chk("sg_disp_lag", disp_o, 32'hCAFE_F00D);

    // saturated counter: a new contender preempts at the next edge
    req_i = 4'b0101;
    step();
    chk("sat_gnt",   32'(gnt_o),   32'h0);
    chk("sat_disp",  disp_o,       32'h0);
    chk("sat_state", 32'(state_o), 32'(SWITCH));

    // ptr=3, only req2 left -> owner 2; req0 raised in the grant cycle
    req_i = 4'b0100;
    step();
    chk("pre_gnt1",  32'(gnt_o),   32'h4);
    chk("pre_owner", 32'(owner_o), 32'h2);
    req_i = 4'b0101;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("pre_hold", 32'(gnt_o), 32'h4);
    end
    step();
    chk("pre_gap_gnt",  32'(gnt_o), 32'h0);
    chk("pre_gap_disp", disp_o,     32'h0);
    step();
    chk("pre_wrap_gnt",   32'(gnt_o),   32'h1);
    chk("pre_wrap_owner", 32'(owner_o), 32'h0);

    // owner 0 releases to req3 (ptr=1 search), then 3 releases -> ptr=0
    req_i = 4'b1000;
    step();
    chk("rel0_gnt", 32'(gnt_o), 32'h0);
    step();
    chk("own3_gnt",   32'(gnt_o),   32'h8);
    chk("own3_owner", 32'(owner_o), 32'h3);
    req_i = 4'b0000;
    step();
    chk("rel3_state", 32'(state_o), 32'(SWITCH));
    step();
    chk("rel3_idle", 32'(state_o), 32'(IDLE));

    // full rotation 0,1,2,3,0 with 4-cycle holds and one-cycle gaps
    req_i = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      for (int c = 0; c < 4; c++) begin
        step();
        chk("rot_gnt",   32'(gnt_o),   32'(4'b0001 << (n % 4)));
        chk("rot_owner", 32'(owner_o), 32'(n % 4));
        chk("rot_disp",  disp_o,       (c == 0) ? 32'h0 : exp_word[n % 4]);
      end
      step();
      chk("rot_gap_gnt",  32'(gnt_o), 32'h0);
      chk("rot_gap_disp", disp_o,     32'h0);
    end

    // voluntary release by owner 1 after 2 cycles, then ptr=2 wraps to 0
    req_i = 4'b0010;
    step();
    chk("vol_gnt1", 32'(gnt_o), 32'h2);
    step();
    chk("vol_gnt2", 32'(gnt_o), 32'h2);
    req_i = 4'b0000;
    step();
    chk("vol_sw_gnt",   32'(gnt_o),   32'h0);
    chk("vol_sw_state", 32'(state_o), 32'(SWITCH));
    step();
    chk("vol_idle", 32'(state_o), 32'(IDLE));
    req_i = 4'b0011;
    step();
    chk("vol_wrap_gnt", 32'(gnt_o), 32'h1);

    // reset while owner 3 holds
    req_i = 4'b1000;
    step();
    step();
    chk("mid_own3", 32'(gnt_o), 32'h8);
    rst_i = 1'b0;
    step();
    chk("mid_rst_gnt",   32'(gnt_o),   32'h0);
    chk("mid_rst_valid", 32'(valid_o), 32'h0);
    chk("mid_rst_disp",  disp_o,       32'h0);
    chk("mid_rst_state", 32'(state_o), 32'(IDLE));
    chk("mid_rst_owner", 32'(owner_o), 32'h0);
    rst_i = 1'b1;
    req_i = 4'b1010;
    step();
    chk("post_rst_gnt",   32'(gnt_o),   32'h2);
    chk("post_rst_owner", 32'(owner_o), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/disp_share_arbiter.md
Name: disp_share_arbiter

Overview:
- Round-robin arbiter that shares the 8-digit seven-segment display between N_REQ requesters.
- Each requester presents a 32-bit hex word.
- The block grants one owner at a time, enforces a minimum on-screen hold time, and forwards the owner's word on disp_o.
- disp_o feeds the data_i input of the 32-bit display scanner.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- HOLD_CLOCKS, 50_000_000, minimum clocks an owner keeps the display when another requester is waiting (>=1).
- IDLE_PATTERN, 32'h0000_0000, word driven on disp_o when nobody owns the display.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_i  in  1  synchronous reset, active-low: rst_i=0 at a rising edge resets the block.
- req_i  in  N_REQ  per-requester level request; held high while the requester wants the display.
- data_i  in  32*N_REQ  requester k's word in bits [32k+31:32k].
- gnt_o  out  N_REQ  one-hot grant, all-zero when no owner.
- owner_o  out  max(1,$clog2(N_REQ))  index of current owner; meaningful only when valid_o=1.
- valid_o  out  1  display currently owned.
- disp_o  out  32  registered word for the display scanner.

Behaviour:
- Reset values (rst_i=0 at an edge): state=IDLE, gnt_o=0, owner_o=0, valid_o=0, disp_o=IDLE_PATTERN, hold counter=0, round-robin pointer=0.
- Reset mid-operation aborts ownership at that edge; no SWITCH gap is inserted.
- States: IDLE, OWN, SWITCH.
- Arbitration (in IDLE and SWITCH):
  - Winner is the first k with req_i[k]=1, searching ptr, ptr+1, ... and wrapping modulo N_REQ.
  - If a winner exists: next edge state=OWN, gnt_o=onehot(k), owner_o=k, valid_o=1, hold counter=0.
  - If no winner: state=IDLE.
- Grant latency: req_i rising while IDLE -> gnt_o asserted at the next edge (1 cycle).
- OWN:
  - Hold counter increments each cycle and saturates at HOLD_CLOCKS-1.
  - Each cycle disp_o <= data_i slice of owner, so disp_o lags data_i by 1 cycle.
  - Go to SWITCH if req_i[owner]=0 (voluntary release, takes effect regardless of the counter).
  - Go to SWITCH if counter==HOLD_CLOCKS-1 and any other req_i bit is 1 (preemption).
  - Otherwise stay in OWN. A sole requester holds the display indefinitely.
  - Release and preemption in the same cycle -> a single SWITCH.
- SWITCH (exactly 1 cycle):
  - gnt_o=0, valid_o=0, disp_o=IDLE_PATTERN.
  - ptr <= (owner+1) mod N_REQ; the search in this cycle already uses the updated pointer.
  - The arbitration result goes to OWN or IDLE at the next edge.
  - Guarantees a one-cycle blank gap between owners and prevents two grants in any cycle.
- IDLE: disp_o=IDLE_PATTERN, valid_o=0. ptr is retained from the last SWITCH.
- Fairness: with all requests constantly high, the grant order is 0,1,...,N_REQ-1,0,... with HOLD_CLOCKS cycles each plus a 1-cycle gap.
- Invariants:
  - gnt_o is one-hot or zero.
  - gnt_o!=0 iff valid_o=1.
  - gnt_o == onehot(owner_o) whenever valid_o=1.
- Width rules:
  - Hold counter width is $clog2(HOLD_CLOCKS+1).
  - Pointer wrap is explicit modulo N_REQ; correct for non-power-of-two N_REQ.

Decomposition:
- Package disp_pkg holds:
  - DISP_W=32 and DIGIT_W=4.
  - The state encoding constants IDLE/OWN/SWITCH.
  - The idx_w function returning max(1,$clog2(n)).
- One sub-module is natural: rr_pick (combinational).
  - Inputs: req vector and ptr. Outputs: any_o and winner index.
  - Double-width masked priority search.
  - Instantiated once.

Test Plan:
- Reset and IDLE: N_REQ=4, HOLD_CLOCKS=4, rst_i=0 for 2 edges with req_i=4'b1111 -> gnt_o=0, valid_o=0, disp_o=32'h0. Release rst_i, req_i=0 -> state remains IDLE, outputs unchanged.
- Single grant: req_i=4'b0100, data2=32'hDEADBEEF -> gnt_o=4'b0100, owner_o=2 after 1 edge; disp_o=32'hDEADBEEF the following edge; held for 20 cycles with no contender.
- Preemption and wrap: owner 2 granted, req0 raised at grant cycle -> gnt_o=4'b0100 for exactly 4 cycles, then gnt_o=0 and disp_o=0 for 1 cycle, then gnt_o=4'b0001 (3 skipped, wraps to 0).
- Full rotation: req_i=4'b1111 from IDLE -> grant sequence 0,1,2,3,0, each 4 cycles, separated by single-cycle zero-grant gaps; never two bits set.
- Voluntary release: owner 1 drops req_i[1] after 2 cycles, others idle -> gnt_o=0 at the next edge (SWITCH), then IDLE. A later req_i=4'b0011 grants index 2 first? No: ptr=2, so the search finds 0 after wrap; expect gnt_o=4'b0001.
- Reset mid-OWN: rst_i=0 while owner 3 holds -> next edge gnt_o=0, valid_o=0, disp_o=0, ptr=0. After release with req_i=4'b1010 -> gnt_o=4'b0010.
